// File: rtl/adder_error_monitor_pkg.sv
// Shared definitions for the adder error-metrics blocks: FSM state encodings and default sizes.
// Reused by the monitor and the companion stimulus generator.
package adder_error_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH      = 4;
    localparam int DEF_SAMPLE_CNT = 256;

endpackage

// File: rtl/adder_error_monitor_error_distance.sv
// Error distance between an exact and an approximate adder result: |diff|, signed diff, mismatch.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module error_distance #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]          exact,
    input  logic [WIDTH:0]          approx,
    output logic [WIDTH:0]          ed,
    output logic signed [WIDTH+1:0] diff,
    output logic                    mismatch
);

    always_comb begin
        ed       = (exact >= approx) ? (exact - approx) : (approx - exact);
        diff     = $signed({1'b0, approx}) - $signed({1'b0, exact});
        mismatch = (exact != approx);
    end

endmodule

// File: rtl/adder_error_monitor.sv
// Accumulates error count, sum/max error distance (and signed bias under ERR_BIAS_EN) over a window.
// Latency: statistics update on the accepting edge; done rises the cycle after the last accept.
// Backpressure: in_ready high only in RUN; samples presented outside RUN are dropped.
module adder_error_monitor
    import adder_error_monitor_pkg::*;
#(
    parameter  int WIDTH      = DEF_WIDTH,
    parameter  int SAMPLE_CNT = DEF_SAMPLE_CNT,
    localparam int CNT_W      = $clog2(SAMPLE_CNT + 1),
    localparam int ACC_W      = WIDTH + 1 + CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   exact_res,
    input  logic [WIDTH:0]   approx_res,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] samples,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] sum_ed,
    output logic [WIDTH:0]   max_ed,
    output logic [ACC_W:0]   bias_sum
);

    state_t state, state_nxt;

    logic [WIDTH:0]          ed;
    logic signed [WIDTH+1:0] diff;
    logic                    mismatch;
    logic                    accept;
    logic                    last;
    logic                    clear;

    error_distance #(.WIDTH(WIDTH)) u_error_distance (
        .exact    (exact_res),
        .approx   (approx_res),
        .ed       (ed),
        .diff     (diff),
        .mismatch (mismatch)
    );

    assign in_ready = (state == ST_RUN);
    assign busy     = (state == ST_RUN);
    assign done     = (state == ST_DONE);
    assign accept   = in_valid && in_ready;
    assign last     = accept && (samples == CNT_W'(SAMPLE_CNT - 1));
    assign clear    = start && (state == ST_IDLE || state == ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last)  state_nxt = ST_DONE;
            ST_DONE: if (start) state_nxt = ST_RUN;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            samples   <= '0;
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
        end else begin
            state <= state_nxt;
            if (clear) begin
                samples   <= '0;
                err_count <= '0;
                sum_ed    <= '0;
                max_ed    <= '0;
            end else if (accept) begin
                samples   <= samples + 1'b1;
                err_count <= err_count + CNT_W'(mismatch);
                sum_ed    <= sum_ed + ACC_W'(ed);
                if (ed > max_ed) max_ed <= ed;
            end
        end
    end

`ifdef ERR_BIAS_EN
    logic signed [ACC_W:0] diff_ext;

    // Signed size cast sign-extends the per-sample difference.
    assign diff_ext = (ACC_W + 1)'(diff);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bias_sum <= '0;
        end else if (clear) begin
            bias_sum <= '0;
        end else if (accept) begin
            bias_sum <= bias_sum + diff_ext;
        end
    end
`else
    logic unused_diff;

    assign unused_diff = ^diff;
    assign bias_sum    = '0;
`endif

endmodule

// File: tb/tb_adder_error_monitor.sv
// Randomised and directed checks of adder_error_monitor (SAMPLE_CNT=4) against a behavioural model.
// Bias expectations follow the ERR_BIAS_EN build setting.
module tb_adder_error_monitor;

    localparam int W     = 4;
    localparam int N     = 4;
    localparam int CNT_W = $clog2(N + 1);
    localparam int ACC_W = W + 1 + CNT_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [W:0]       exact_res;
    logic [W:0]       approx_res;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] samples;
    logic [CNT_W-1:0] err_count;
    logic [ACC_W-1:0] sum_ed;
    logic [W:0]       max_ed;
    logic [ACC_W:0]   bias_sum;

    adder_error_monitor #(.WIDTH(W), .SAMPLE_CNT(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .exact_res  (exact_res),
        .approx_res (approx_res),
        .busy       (busy),
        .done       (done),
        .samples    (samples),
        .err_count  (err_count),
        .sum_ed     (sum_ed),
        .max_ed     (max_ed),
        .bias_sum   (bias_sum)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: window phase and running statistics as plain integers.
    int m_phase;  // 0 idle, 1 collecting, 2 complete
    int m_samples, m_err, m_sum, m_max, m_bias;

    task automatic check(input string tag, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic m_clear();
        m_samples = 0; m_err = 0; m_sum = 0; m_max = 0; m_bias = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one cycle of inputs, advance the model, step the clock.
    task automatic cycle(input bit v, input int e, input int a, input bit st);
        int ed;
        in_valid   = v;
        exact_res  = 5'(e);
        approx_res = 5'(a);
        start      = st;
        check("in_ready", in_ready, m_phase == 1);
        if (m_phase == 1) begin
            if (v) begin
                ed = (e > a) ? e - a : a - e;
                m_samples++;
                if (ed != 0) m_err++;
                m_sum  += ed;
                m_bias += a - e;
                if (ed > m_max) m_max = ed;
                if (m_samples == N) m_phase = 2;
            end
        end else if (st) begin
            m_clear();
            m_phase = 1;
        end
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic check_stats(input string tag);
        check({tag, ".samples"}, samples, m_samples);
        check({tag, ".err"}, err_count, m_err);
        check({tag, ".sum"}, sum_ed, m_sum);
        check({tag, ".max"}, max_ed, m_max);
`ifdef ERR_BIAS_EN
        check({tag, ".bias"}, longint'($signed(bias_sum)), m_bias);
`else
        check({tag, ".bias"}, longint'($signed(bias_sum)), 0);
`endif
        check({tag, ".done"}, done, m_phase == 2);
        check({tag, ".busy"}, busy, m_phase == 1);
    endtask

    int mix_e[4] = '{10, 3, 31, 6};
    int mix_a[4] = '{8, 7, 0, 6};
    bit vpat[7]  = '{1, 0, 0, 1, 1, 0, 1};

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; exact_res = '0; approx_res = '0;
        m_phase = 0; m_clear();
        #1;
        check_stats("reset");
        check("reset.in_ready", in_ready, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Exact-match window
        cycle(0, 0, 0, 1);
        check_stats("start");
        for (int i = 0; i < N; i++) cycle(1, 10, 10, 0);
        check_stats("exact");
        check("exact.done", done, 1);

        // Mixed errors with valid gaps; start pulsed mid-window is ignored
        cycle(0, 0, 0, 1);
        k = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) check("gap.done_before", done, 0);
            if (vpat[i]) begin
                cycle(1, mix_e[k], mix_a[k], 0);
                k++;
            end else begin
                cycle(0, 31, 0, i == 2);
            end
        end
        check_stats("mixed");
        check("mixed.err", err_count, 3);
        check("mixed.sum", sum_ed, 37);
        check("mixed.max", max_ed, 31);
`ifdef ERR_BIAS_EN
        check("mixed.bias", longint'($signed(bias_sum)), -29);
`else
        check("mixed.bias", longint'($signed(bias_sum)), 0);
`endif

        // in_valid during DONE is ignored
        for (int i = 0; i < 3; i++) cycle(1, 1, 20, 0);
        check_stats("done_hold");

        // start in DONE clears and reopens
        cycle(0, 0, 0, 1);
        check_stats("restart");

        // Partial window then asynchronous reset
        for (int i = 0; i < 3; i++) cycle(1, 2 + i, 9, 0);
        check("pre_rst.samples", samples, 3);
        #2;
        rst = 1'b1;
        #1;
        m_phase = 0; m_clear();
        check_stats("midrst");
        check("midrst.in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        tick();

        // Random windows
        for (int w = 0; w < 6; w++) begin
            int budget;
            int e, a;
            cycle(0, 0, 0, 1);
            budget = 0;
            while (m_phase == 1 && budget < 40) begin
                e = int'($urandom_range(0, 31));
                a = ($urandom_range(0, 3) == 0) ? e : int'($urandom_range(0, 31));
                cycle(1'($urandom_range(0, 1)), e, a, 1'($urandom_range(0, 7) == 0));
                budget++;
            end
            check("rand.window_closed", m_phase, 2);
            check_stats("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
